// File: rtl/conv_channel_accum_if.sv
// Handshake bundle between the dot_product feed and the channel accumulator.
// Master drives start/in_v/in_data/bias; slave returns out/out_v/sat/busy.
interface conv_channel_accum_if #(
  parameter int W = 16
);
  logic                start;
  logic                in_v;
  logic signed [W-1:0] in_data;
  logic signed [W-1:0] bias;
  logic signed [W-1:0] out;
  logic                out_v;
  logic                sat;
  logic                busy;

  modport master (
    output start,
    output in_v,
    output in_data,
    output bias,
    input  out,
    input  out_v,
    input  sat,
    input  busy
  );

  modport slave (
    input  start,
    input  in_v,
    input  in_data,
    input  bias,
    output out,
    output out_v,
    output sat,
    output busy
  );
endinterface

// File: rtl/conv_channel_accum.sv
// Sums C partial products plus bias, optional ReLU, saturates to W bits.
// Ports: clk, rst (async active-low), bus (slave: start, in_v, in_data,
// bias -> out, out_v, sat, busy).
module conv_channel_accum #(
  parameter int W    = 16,
  parameter int C    = 4,
  parameter int RELU = 1
) (
  input logic                  clk,
  input logic                  rst,
  conv_channel_accum_if.slave  bus
);

  localparam int LW = $clog2(C);
  localparam int CW = LW + 1;
  localparam int AW = W + LW + 1;

  localparam logic [CW-1:0] LAST = CW'(C - 1);

  localparam logic signed [AW-1:0] MAXV =
    {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  localparam logic signed [W-1:0] OMAX =
    {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] OMIN =
    {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    BIAS,
    ACT
  } state_t;

  state_t state, state_n;

  logic signed [AW-1:0] acc, acc_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic signed [W-1:0]  out_q, out_n;
  logic                 sat_q, sat_n;
  logic                 ov_q, ov_n;

  logic signed [AW-1:0] in_ext;
  logic signed [AW-1:0] bias_ext;
  logic signed [AW-1:0] r;

  assign in_ext   = {{(AW-W){bus.in_data[W-1]}}, bus.in_data};
  assign bias_ext = {{(AW-W){bus.bias[W-1]}}, bus.bias};

  // ReLU ahead of the clip so a clamp to zero never reports saturation.
  assign r = ((RELU != 0) && acc[AW-1]) ? '0 : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      out_q <= '0;
      sat_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      out_q <= out_n;
      sat_q <= sat_n;
      ov_q  <= ov_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    out_n   = out_q;
    sat_n   = sat_q;
    ov_n    = 1'b0;

    if (bus.start) begin
      // restart wins over whatever was in flight
      acc_n   = '0;
      cnt_n   = '0;
      state_n = ACCUM;
    end else begin
      unique case (state)
        IDLE: begin
        end
        ACCUM: begin
          if (bus.in_v) begin
            acc_n = acc + in_ext;
            cnt_n = cnt + CW'(1);
            if (cnt == LAST) begin
              state_n = BIAS;
            end
          end
        end
        BIAS: begin
          acc_n   = acc + bias_ext;
          state_n = ACT;
        end
        ACT: begin
          unique case (1'b1)
            (r > MAXV): begin
              out_n = OMAX;
              sat_n = 1'b1;
            end
            (r < MINV): begin
              out_n = OMIN;
              sat_n = 1'b1;
            end
            default: begin
              out_n = r[W-1:0];
              sat_n = 1'b0;
            end
          endcase
          ov_n    = 1'b1;
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.out   = out_q;
  assign bus.out_v = ov_q;
  assign bus.sat   = sat_q;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_conv_channel_accum.sv
// Random and directed bench for conv_channel_accum, RELU=1 and RELU=0 in
// parallel, checked against an arithmetic sum/relu/clip reference.
module tb_conv_channel_accum;

  localparam int W = 16;
  localparam int C = 4;

  localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W-1));

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  logic                start   = 1'b0;
  logic                in_v    = 1'b0;
  logic signed [W-1:0] in_data = '0;
  logic signed [W-1:0] bias    = '0;

  conv_channel_accum_if #(.W(W)) if1 ();
  conv_channel_accum_if #(.W(W)) if0 ();

  assign if1.start   = start;
  assign if1.in_v    = in_v;
  assign if1.in_data = in_data;
  assign if1.bias    = bias;
  assign if0.start   = start;
  assign if0.in_v    = in_v;
  assign if0.in_data = in_data;
  assign if0.bias    = bias;

  conv_channel_accum #(.W(W), .C(C), .RELU(1)) u_r1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  conv_channel_accum #(.W(W), .C(C), .RELU(0)) u_r0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  int checks   = 0;
  int failures = 0;
  int ov1      = 0;
  int ov0      = 0;
  int nres     = 0;

  longint h1_o = 0, h1_s = 0;
  longint h0_o = 0, h0_s = 0;
  longint pq[$];

  always @(posedge clk) begin
    if (if1.out_v) ov1++;
    if (if0.out_v) ov0++;
  end

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input longint s, input bit relu,
                                output longint o, output longint sa);
    if (relu && s < 0) s = 0;
    if (s > MAXV) begin
      o = MAXV; sa = 1;
    end else if (s < MINV) begin
      o = MINV; sa = 1;
    end else begin
      o = s; sa = 0;
    end
  endfunction

  task automatic hold_chk();
    chk("hold_out1", if1.out, h1_o);
    chk("hold_out0", if0.out, h0_o);
    chk("hold_sat1", if1.sat, h1_s);
    chk("hold_ov1", if1.out_v, 0);
    chk("hold_ov0", if0.out_v, 0);
  endtask

  task automatic set4(input longint a, input longint b,
                      input longint c, input longint d);
    pq.delete();
    pq.push_back(a);
    pq.push_back(b);
    pq.push_back(c);
    pq.push_back(d);
  endtask

  // start pulse, partials from pq with gap idle cycles before each,
  // ends on the negedge where out_v should be high
  task automatic run_seq(input longint b, input int gap);
    longint s, e1o, e1s, e0o, e0s;
    s = b;
    foreach (pq[i]) s += pq[i];
    bias    = W'(b);
    start   = 1'b1;
    in_v    = 1'($urandom_range(0, 1));
    in_data = W'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", if1.busy, 1);
    foreach (pq[i]) begin
      repeat (gap) begin
        in_v    = 1'b0;
        in_data = W'($urandom);
        @(negedge clk);
        hold_chk();
      end
      in_v    = 1'b1;
      in_data = W'(pq[i]);
      @(negedge clk);
      in_v = 1'b0;
      hold_chk();
    end
    chk("busy_n1", if0.busy, 1);
    @(negedge clk);
    hold_chk();
    chk("busy_n2", if1.busy, 1);
    @(negedge clk);
    model(s, 1'b1, e1o, e1s);
    model(s, 1'b0, e0o, e0s);
    chk("out1", if1.out, e1o);
    chk("sat1", if1.sat, e1s);
    chk("out0", if0.out, e0o);
    chk("sat0", if0.sat, e0s);
    chk("ov1", if1.out_v, 1);
    chk("ov0", if0.out_v, 1);
    chk("busy_fall", if1.busy, 0);
    h1_o = e1o; h1_s = e1s;
    h0_o = e0o; h0_s = e0s;
    nres++;
  endtask

  task automatic idle_noise(input int n);
    @(negedge clk);
    repeat (n) begin
      in_v    = 1'($urandom_range(0, 1));
      in_data = W'($urandom);
      @(negedge clk);
      hold_chk();
      chk("idle_busy", if1.busy, 0);
    end
    in_v = 1'b0;
  endtask

  task automatic abort_pre();
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    in_v    = 1'b1;
    in_data = 16'sd7;
    @(negedge clk);
    in_data = 16'sd9;
    @(negedge clk);
    in_v = 1'b0;
  endtask

  longint rp;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", if1.out, 0);
    chk("rst_ov", if1.out_v, 0);
    chk("rst_sat", if0.sat, 0);
    chk("rst_busy", if0.busy, 0);
    rst = 1'b1;
    @(negedge clk);

    set4(100, 200, -50, 25);
    run_seq(10, 0);
    idle_noise(2);
    set4(-1000, -1000, -1000, -1000);
    run_seq(0, 0);
    idle_noise(1);
    set4(30000, 30000, 30000, 30000);
    run_seq(0, 0);
    idle_noise(1);
    set4(-30000, -30000, -30000, -30000);
    run_seq(0, 1);
    idle_noise(5);

    abort_pre();
    set4(1, 1, 1, 1);
    run_seq(0, 3);
    idle_noise(4);

    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    in_v    = 1'b1;
    in_data = 16'sd50;
    @(negedge clk);
    in_v = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_out1", if1.out, 0);
    chk("arst_out0", if0.out, 0);
    chk("arst_ov", if1.out_v, 0);
    chk("arst_sat", if1.sat, 0);
    chk("arst_busy", if1.busy, 0);
    h1_o = 0; h1_s = 0; h0_o = 0; h0_s = 0;
    @(negedge clk);
    rst = 1'b1;
    idle_noise(2);
    set4(100, 200, -50, 25);
    run_seq(10, 0);

    set4(1, 2, 3, 4);
    run_seq(-20, 0);
    idle_noise(2);

    for (int k = 0; k < 40; k++) begin
      pq.delete();
      for (int j = 0; j < C; j++) begin
        if ($urandom_range(0, 3) == 0)
          rp = longint'($urandom_range(0, 200)) - 100;
        else
          rp = longint'($urandom_range(0, 65535)) - 32768;
        pq.push_back(rp);
      end
      if ($urandom_range(0, 5) == 0) abort_pre();
      run_seq(longint'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 2)));
      if ($urandom_range(0, 2) != 0)
        idle_noise(int'($urandom_range(0, 3)));
    end

    in_v = 1'b0;
    repeat (3) @(negedge clk);
    chk("ov_count1", ov1, nres);
    chk("ov_count0", ov0, nres);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_channel_accum.md
# conv_channel_accum

Accumulates the per-input-channel partial sums produced by a `dot_product` unit into one output-channel value. It adds a per-channel bias, applies an optional ReLU, and saturates the result to W bits. The block sits directly downstream of `dot_product` inside the `network` sequencer, which pulses `start` once per output channel and routes each `dot_product` `out`/`out_v` pair into it. The registered result feeds the next layer's activation buffer.

## Interface
- `W`, 16: sample/activation width, signed fixed point, same format as `dot_product` `out`.
- `C`, 4: number of partial sums (input channels) per result; C >= 1.
- `RELU`, 1: 1 = clamp negative results to 0; 0 = pass signed results through.
- `clk`  in  1  system clock; every register is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse: clear accumulator, begin a new result (aborts any in-flight result).
- `in_v`  in  1  partial-sum valid; connect to `dot_product` `out_v`.
- `in_data`  in  W  signed partial sum; sampled only when `in_v`=1.
- `bias`  in  W  signed bias; must be stable from `start` until `out_v`.
- `out`  out  W  signed registered result; holds until the next result.
- `out_v`  out  1  one-cycle pulse when `out` is updated.
- `sat`  out  1  registered with `out`; 1 = the result was clipped to the W-bit range. Updated only on `out_v`.
- `busy`  out  1  1 whenever state != IDLE.

## Operation
- Accumulator `acc` is AW = W + $clog2(C) + 1 bits signed. Every operand is sign-extended to AW, so the sum of C partials plus bias never wraps internally.
- Partial counter `cnt` is $clog2(C)+1 bits wide.
- States and transitions:
  - IDLE: `start` -> acc<=0, cnt<=0, go to ACCUM. `in_v` is ignored.
  - ACCUM: `in_v` -> acc<=acc+sext(in_data), cnt<=cnt+1. When `in_v` arrives with cnt==C-1, go to BIAS. Cycles with `in_v`=0 are allowed anywhere in the sequence; the block waits indefinitely.
  - BIAS: acc<=acc+sext(bias), go to ACT. `in_v` is ignored.
  - ACT: r = (RELU && acc<0) ? 0 : acc. The output is loaded from r: out<=clip(r), sat<=(r>2^(W-1)-1 || r<-2^(W-1)), out_v<=1, go to IDLE.
- clip() saturates to [-2^(W-1), 2^(W-1)-1]. A ReLU clamp to 0 does not set `sat`.
- `start` has priority in every state. In ACCUM, BIAS or ACT it restarts: acc<=0, cnt<=0, go to ACCUM, and no `out_v` is produced for the aborted result. An `in_v` in the same cycle as `start` is dropped.
- `out_v` is cleared the cycle after it is asserted. `out` and `sat` hold their value until the next ACT.
- Reset values (asynchronous, while rst=0): state=IDLE, acc=0, cnt=0, out=0, out_v=0, sat=0, busy=0.
- Reset deasserted mid-operation: the block resumes in IDLE, and no partial result is emitted.

## Timing
- Cycle n = the clock edge that samples the C-th `in_v`.
- Edge n+1: bias added.
- Edge n+2: out/sat/out_v registered. `out_v` is high for exactly the cycle following edge n+2.
- Minimum time from `start` to `out_v`: C+2 edges (`in_v` back-to-back starting the cycle after `start`).
- `busy` rises on the edge that samples `start`. It falls on edge n+2, the same edge that raises `out_v`.
- A `start` in the same cycle as `out_v`=1 is legal: the new result begins and the current `out` stays valid.
- Throughput: one result per C+3 cycles at full `in_v` rate.

## Test plan
- Basic, W=16, C=4, RELU=1: start, then in_data 100, 200, -50, 25 back-to-back, bias=10. Expect out=285, sat=0, a single `out_v` pulse 2 cycles after the last `in_v`, and busy low on that same edge.
- ReLU: four partials of -1000, bias=0. Expect out=0 and sat=0. Same inputs with RELU=0: expect out=-4000.
- Saturation: four partials of 30000, bias=0. Expect out=32767 and sat=1. With RELU=0, four partials of -30000: expect out=-32768 and sat=1.
- Abort and gaps: start, partials 7 and 9, start again, then four partials of 1 separated by 3 idle cycles each, bias=0. Expect exactly one `out_v` with out=4. `in_v` pulses while IDLE must not change `out`.
- Async reset: assert rst=0 mid-ACCUM between clock edges. out, out_v, sat and busy must be 0 before the next edge. After release, run the basic case and expect out=285.
- Back-to-back: issue `start` in the `out_v` cycle, then a second sequence of 1, 2, 3, 4 with bias=-20. Expect the first out to hold until the second `out_v`, which carries out=-10.
